// File: rtl/servo_pulse_gen_pkg.sv
// Shared types and 50 MHz timing defaults for the servo pulse generator and the motor-control stage.
package servo_pulse_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } stateT;

  localparam int unsigned CNT_W_DEFAULT       = 21;
  localparam int unsigned NUM_W               = 10;

  // 20 ms frame and 2.5 ms high-time clamp at 50 MHz
  localparam int unsigned FRAME_CYCLES_50MHZ  = 1000000;
  localparam int unsigned MAX_HIGH_50MHZ      = 125000;

  // Continuous-rotation servo commands shared with motor control
  localparam int unsigned SERVO_NEUTRAL_50MHZ = 75000;
  localparam int unsigned SERVO_FORWARD_50MHZ = 100000;
  localparam int unsigned SERVO_REVERSE_50MHZ = 50000;

endpackage

// File: rtl/servo_pwm_channel.sv
// One servo PWM line: registered compare of the next frame counter against the next high time.
module servo_pwm_channel #(
  parameter int unsigned CNT_W = 21
) (
  input  logic             iClk,
  input  logic             iRST,
  input  logic             iEnable,
  input  logic [CNT_W-1:0] iHi,
  input  logic [CNT_W-1:0] iFc,
  output logic             oPwm
);

  // Inputs are next-cycle values, so the flop output lines up with the frame counter register
  always_ff @(posedge iClk) begin
    if (iRST) begin
      oPwm <= 1'b0;
    end else begin
      oPwm <= iEnable && (iFc < iHi);
    end
  end

endmodule

// File: rtl/servo_pulse_gen.sv
// Burst generator for the two tracked-robot servo PWM lines: N frames per command, then a rest gap.
module servo_pulse_gen
  import servo_pulse_gen_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES = FRAME_CYCLES_50MHZ,
  parameter int unsigned MAX_HIGH     = MAX_HIGH_50MHZ,
  parameter int unsigned GAP_FRAMES   = 1,
  parameter int unsigned CNT_W        = CNT_W_DEFAULT
) (
  input  logic             iClk,
  input  logic             iRST,
  input  logic [CNT_W-1:0] iLeftMotor,
  input  logic [CNT_W-1:0] iRightMotor,
  input  logic [NUM_W-1:0] iNumPulses,
  input  logic             iHalt,
  output logic             oLeftPwm,
  output logic             oRightPwm,
  output logic             oBusy,
  output logic             oDone,
  output logic [NUM_W-1:0] oPulsesLeft
);

  localparam int unsigned GAP_W = (GAP_FRAMES > 1) ? $clog2(GAP_FRAMES) : 1;
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [CNT_W-1:0] HIGH_CLAMP = CNT_W'(MAX_HIGH);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP_FRAMES - 1);

  if ((longint'(FRAME_CYCLES) - 1) >= (longint'(1) << CNT_W)) begin : gFrameWidthCheck
    $error("FRAME_CYCLES-1 does not fit in CNT_W bits");
  end
  if (MAX_HIGH >= FRAME_CYCLES) begin : gClampCheck
    $error("MAX_HIGH must be below FRAME_CYCLES");
  end

  stateT            state;
  stateT            nextState;
  logic [CNT_W-1:0] fc;
  logic [CNT_W-1:0] fcNext;
  logic [CNT_W-1:0] hiL;
  logic [CNT_W-1:0] hiLNext;
  logic [CNT_W-1:0] hiR;
  logic [CNT_W-1:0] hiRNext;
  logic [NUM_W-1:0] cnt;
  logic [NUM_W-1:0] cntNext;
  logic [GAP_W-1:0] gapCnt;
  logic [GAP_W-1:0] gapCntNext;
  logic             finish;
  logic             frameEnd;
  logic             busyNext;
  logic             doneNext;
  logic             pwmEnable;

  assign frameEnd = (fc == FRAME_LAST);

  // State register
  always_ff @(posedge iClk) begin
    if (iRST) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and datapath updates; halt overrides every state
  always_comb begin
    nextState  = state;
    fcNext     = fc;
    hiLNext    = hiL;
    hiRNext    = hiR;
    cntNext    = cnt;
    gapCntNext = gapCnt;
    finish     = 1'b0;
    if (iHalt) begin
      nextState  = IDLE;
      fcNext     = '0;
      cntNext    = '0;
      gapCntNext = '0;
    end else begin
      case (state)
        IDLE: begin
          if (iNumPulses != '0) begin
            nextState = BURST;
            fcNext    = '0;
            hiLNext   = (iLeftMotor  > HIGH_CLAMP) ? HIGH_CLAMP : iLeftMotor;
            hiRNext   = (iRightMotor > HIGH_CLAMP) ? HIGH_CLAMP : iRightMotor;
            cntNext   = iNumPulses;
          end
        end
        BURST: begin
          if (frameEnd) begin
            fcNext  = '0;
            cntNext = cnt - NUM_W'(1);
            if (cnt == NUM_W'(1)) begin
              gapCntNext = '0;
              if (GAP_FRAMES > 0) begin
                nextState = GAP;
              end else begin
                nextState = IDLE;
                finish    = 1'b1;
              end
            end
          end else begin
            fcNext = fc + CNT_W'(1);
          end
        end
        GAP: begin
          if (frameEnd) begin
            fcNext = '0;
            if (gapCnt == GAP_LAST) begin
              nextState  = IDLE;
              gapCntNext = '0;
              finish     = 1'b1;
            end else begin
              gapCntNext = gapCnt + GAP_W'(1);
            end
          end else begin
            fcNext = fc + CNT_W'(1);
          end
        end
        default: begin
          nextState = IDLE;
          fcNext    = '0;
          cntNext   = '0;
        end
      endcase
    end
  end

  // Next values of the registered status outputs
  always_comb begin
    busyNext  = 1'b0;
    doneNext  = 1'b0;
    pwmEnable = 1'b0;
    busyNext  = (nextState != IDLE);
    doneNext  = finish;
    pwmEnable = (nextState == BURST);
  end

  always_ff @(posedge iClk) begin
    if (iRST) begin
      fc          <= '0;
      hiL         <= '0;
      hiR         <= '0;
      cnt         <= '0;
      gapCnt      <= '0;
      oBusy       <= 1'b0;
      oDone       <= 1'b0;
    end else begin
      fc          <= fcNext;
      hiL         <= hiLNext;
      hiR         <= hiRNext;
      cnt         <= cntNext;
      gapCnt      <= gapCntNext;
      oBusy       <= busyNext;
      oDone       <= doneNext;
    end
  end

  assign oPulsesLeft = cnt;

  servo_pwm_channel #(
    .CNT_W (CNT_W)
  ) uLeft (
    .iClk    (iClk),
    .iRST    (iRST),
    .iEnable (pwmEnable),
    .iHi     (hiLNext),
    .iFc     (fcNext),
    .oPwm    (oLeftPwm)
  );

  servo_pwm_channel #(
    .CNT_W (CNT_W)
  ) uRight (
    .iClk    (iClk),
    .iRST    (iRST),
    .iEnable (pwmEnable),
    .iHi     (hiRNext),
    .iFc     (fcNext),
    .oPwm    (oRightPwm)
  );

endmodule

// File: tb/tb_servo_pulse_gen.sv
// Self-checking bench for servo_pulse_gen with a short frame (100 cycles), clamp 40 and one gap frame.
module tb_servo_pulse_gen;

  localparam int FRAME = 100;
  localparam int MAXH  = 40;
  localparam int GAPF  = 1;
  localparam int CW    = 21;

  logic          iClk = 1'b0;
  logic          iRST;
  logic          iHalt;
  logic [CW-1:0] iLeftMotor;
  logic [CW-1:0] iRightMotor;
  logic [9:0]    iNumPulses;
  logic          oLeftPwm;
  logic          oRightPwm;
  logic          oBusy;
  logic          oDone;
  logic [9:0]    oPulsesLeft;

  always #5 iClk = ~iClk;

  servo_pulse_gen #(
    .FRAME_CYCLES (FRAME),
    .MAX_HIGH     (MAXH),
    .GAP_FRAMES   (GAPF),
    .CNT_W        (CW)
  ) dut (
    .iClk        (iClk),
    .iRST        (iRST),
    .iLeftMotor  (iLeftMotor),
    .iRightMotor (iRightMotor),
    .iNumPulses  (iNumPulses),
    .iHalt       (iHalt),
    .oLeftPwm    (oLeftPwm),
    .oRightPwm   (oRightPwm),
    .oBusy       (oBusy),
    .oDone       (oDone),
    .oPulsesLeft (oPulsesLeft)
  );

  typedef struct {
    int l;
    int r;
    int n;
    int chgAt;
  } vecT;

  typedef struct {
    int hiL;
    int hiR;
    int n;
    int busyCycles;
    int doneAt;
    int p1;
    int p2;
  } expT;

  int  checks   = 0;
  int  failures = 0;
  vecT vecs[5];
  expT sb[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One command: expectations pushed at drive time, popped and compared after oDone
  task automatic runVec(input vecT v, input int idx);
    expT e;
    expT got;
    int  errL = 0, errR = 0, errB = 0, doneAt = 0, doneW = 0, p1 = -1, p2 = -1, pEnd = -1;
    int  lim;
    bit  expL, expR, expB;
    e.hiL        = (v.l > MAXH) ? MAXH : v.l;
    e.hiR        = (v.r > MAXH) ? MAXH : v.r;
    e.n          = v.n;
    e.busyCycles = (v.n + GAPF) * FRAME;
    e.doneAt     = e.busyCycles + 1;
    e.p1         = v.n;
    e.p2         = (v.n > 1) ? v.n - 1 : 0;
    lim          = e.doneAt + 1;
    @(negedge iClk);
    iLeftMotor  = CW'(v.l);
    iRightMotor = CW'(v.r);
    iNumPulses  = 10'(v.n);
    sb.push_back(e);
    for (int k = 1; k <= lim; k++) begin
      @(negedge iClk);
      expL = (k <= e.n * FRAME) && (((k - 1) % FRAME) < e.hiL);
      expR = (k <= e.n * FRAME) && (((k - 1) % FRAME) < e.hiR);
      expB = (k <= e.busyCycles);
      if (oLeftPwm != expL) errL++;
      if (oRightPwm != expR) errR++;
      if (oBusy != expB) errB++;
      if (oDone) begin
        doneW++;
        if (doneAt == 0) doneAt = k;
      end
      if (k == 1) p1 = int'(oPulsesLeft);
      if (k == FRAME + 1) p2 = int'(oPulsesLeft);
      if (k == lim) pEnd = int'(oPulsesLeft);
      if (k == ((v.chgAt > 0) ? v.chgAt : 1)) begin
        iLeftMotor  = CW'(10);
        iRightMotor = CW'(5);
        iNumPulses  = '0;
      end
    end
    got = sb.pop_front();
    check($sformatf("v%0d left_shape_errors", idx), errL, 0);
    check($sformatf("v%0d right_shape_errors", idx), errR, 0);
    check($sformatf("v%0d busy_errors", idx), errB, 0);
    check($sformatf("v%0d done_cycle", idx), doneAt, got.doneAt);
    check($sformatf("v%0d done_width", idx), doneW, 1);
    check($sformatf("v%0d pulses_frame0", idx), p1, got.p1);
    check($sformatf("v%0d pulses_frame1", idx), p2, got.p2);
    check($sformatf("v%0d pulses_idle", idx), pEnd, 0);
  endtask

  // Abort in the second frame at fc=15, via halt or reset, then accept a fresh command
  task automatic runAbort(input bit useRst);
    string tag;
    int    doneSeen = 0;
    int    doneAt = 0;
    tag = useRst ? "rst" : "halt";
    @(negedge iClk);
    iLeftMotor  = CW'(30);
    iRightMotor = CW'(30);
    iNumPulses  = 10'd3;
    for (int k = 1; k <= FRAME + 16; k++) begin
      @(negedge iClk);
      if (k == 1) iNumPulses = '0;
    end
    check({tag, " pre_abort_pwm"}, int'({oLeftPwm, oRightPwm, oBusy}), 7);
    check({tag, " pre_abort_pulses"}, int'(oPulsesLeft), 2);
    if (useRst) iRST = 1'b1;
    else iHalt = 1'b1;
    iNumPulses = 10'd1;
    iLeftMotor = CW'(10);
    for (int j = 1; j <= 3; j++) begin
      @(negedge iClk);
      if (oDone) doneSeen++;
      if (j == 1) check({tag, " abort_outputs"}, int'({oLeftPwm, oRightPwm, oBusy, oPulsesLeft}), 0);
      if (j == 3) check({tag, " held_no_accept"}, int'(oBusy), 0);
    end
    iRST  = 1'b0;
    iHalt = 1'b0;
    @(negedge iClk);
    iNumPulses = '0;
    check({tag, " reaccept"}, int'({oLeftPwm, oBusy, oPulsesLeft}), (3 << 10) | 1);
    for (int k = 2; k <= 400 && doneAt == 0; k++) begin
      @(negedge iClk);
      if (oDone) doneAt = k;
    end
    check({tag, " no_done_after_abort"}, doneSeen, 0);
    check({tag, " reaccept_done_cycle"}, doneAt, (1 + GAPF) * FRAME + 1);
    @(negedge iClk);
  endtask

  // Held command: each burst restarts in the oDone cycle
  task automatic runBackToBack();
    int  rises[$];
    bit  prev = 1'b0;
    bit  draining = 1'b1;
    @(negedge iClk);
    iLeftMotor  = CW'(30);
    iRightMotor = CW'(30);
    iNumPulses  = 10'd1;
    for (int k = 1; k <= 900 && rises.size() < 3; k++) begin
      @(negedge iClk);
      if (oLeftPwm && !prev) rises.push_back(k);
      prev = oLeftPwm;
    end
    iNumPulses = '0;
    check("b2b rise_count", rises.size(), 3);
    if (rises.size() == 3) begin
      check("b2b first_rise", rises[0], 1);
      check("b2b period0", rises[1] - rises[0], (1 + GAPF) * FRAME + 1);
      check("b2b period1", rises[2] - rises[1], (1 + GAPF) * FRAME + 1);
    end
    for (int k = 0; k < 500 && draining; k++) begin
      @(negedge iClk);
      if (!oBusy) draining = 1'b0;
    end
    check("b2b drained", int'(draining), 0);
  endtask

  initial begin
    vecs[0] = '{l: 30, r: 20, n: 2, chgAt: 0};
    vecs[1] = '{l: 50, r: 0,  n: 1, chgAt: 0};
    vecs[2] = '{l: 30, r: 20, n: 3, chgAt: FRAME + 1};
    vecs[3] = '{l: 0,  r: 41, n: 1, chgAt: 0};
    vecs[4] = '{l: 1,  r: 39, n: 2, chgAt: 0};

    iRST        = 1'b1;
    iHalt       = 1'b0;
    iLeftMotor  = '0;
    iRightMotor = '0;
    iNumPulses  = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge iClk);
      check($sformatf("reset_outputs_%0d", i), int'({oLeftPwm, oRightPwm, oBusy, oDone, oPulsesLeft}), 0);
      iLeftMotor  = CW'($urandom);
      iRightMotor = CW'($urandom);
      iNumPulses  = 10'($urandom_range(1, 1023));
      iHalt       = 1'($urandom);
    end
    iNumPulses = '0;
    iHalt      = 1'b0;
    iRST       = 1'b0;
    repeat (3) @(negedge iClk);
    check("idle_after_reset", int'({oLeftPwm, oRightPwm, oBusy, oDone}), 0);

    for (int i = 0; i < 5; i++) runVec(vecs[i], i);
    runAbort(1'b0);
    runAbort(1'b1);
    runBackToBack();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
